// File: rtl/audio_spi_i2s_bridge_if.sv
// audio_spi_i2s_bridge_if
// Bundles the serial-side signals of the SPI-in / I2S-out audio bridge.
//   spi_chip_select    : active-low SPI frame enable (master -> bridge)
//   spi_mosi           : SPI data, MSB first (master -> bridge)
//   i2s_ws             : I2S word select, 0 = left, 1 = right (bridge -> master)
//   i2s_sound_bit_out  : I2S serial data (bridge -> master)
//   fifo_level         : sample FIFO occupancy (bridge -> master)
//   overrun_pulse      : completed word dropped, FIFO full
//   underrun_pulse     : left slot started without enough data
//   frame_error_pulse  : chip select rose mid-word
interface audio_spi_i2s_bridge_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic             spi_chip_select;
    logic             spi_mosi;
    logic             i2s_ws;
    logic             i2s_sound_bit_out;
    logic [LVL_W-1:0] fifo_level;
    logic             overrun_pulse;
    logic             underrun_pulse;
    logic             frame_error_pulse;

    // master: the SPI source / I2S sink side
    modport master (
        output spi_chip_select, spi_mosi,
        input  i2s_ws, i2s_sound_bit_out, fifo_level,
               overrun_pulse, underrun_pulse, frame_error_pulse
    );

    // slave: the bridge itself
    modport slave (
        input  spi_chip_select, spi_mosi,
        output i2s_ws, i2s_sound_bit_out, fifo_level,
               overrun_pulse, underrun_pulse, frame_error_pulse
    );
endinterface

// File: rtl/audio_spi_i2s_bridge.sv
// audio_spi_i2s_bridge
// Captures SPI_WIDTH-bit samples from an SPI master, optionally converts
// offset binary to two's complement, buffers them in a FIFO and plays them
// out through a free-running I2S serializer (mono or stereo), everything on
// the rising edge of serial_clk.
// Ports:
//   serial_clk : single clock for capture and I2S bit clock
//   reset      : asynchronous active-low reset
//   bus        : audio_spi_i2s_bridge_if.slave (SPI inputs, I2S + status outputs)
module audio_spi_i2s_bridge #(
    parameter int SPI_WIDTH  = 12,
    parameter int I2S_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter bit STEREO     = 1'b1,
    parameter bit SIGNED_IN  = 1'b1
) (
    input logic                   serial_clk,
    input logic                   reset,
    audio_spi_i2s_bridge_if.slave bus
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BC_W  = $clog2(SPI_WIDTH);
    localparam int PH_W  = $clog2(2 * I2S_WIDTH);
    localparam int NEED  = STEREO ? 2 : 1;

    localparam logic [BC_W-1:0]      BC_LAST  = BC_W'(SPI_WIDTH - 1);
    localparam logic [PH_W-1:0]      PH_LAST  = PH_W'(2 * I2S_WIDTH - 1);
    localparam logic [PH_W-1:0]      PH_RIGHT = PH_W'(I2S_WIDTH);
    localparam logic [LVL_W-1:0]     LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]     LVL_NEED = LVL_W'(NEED);
    // offset binary -> two's complement is a flip of the MSB
    localparam logic [SPI_WIDTH-1:0] MSB_FLIP =
        SIGNED_IN ? '0 : (SPI_WIDTH'(1) << (SPI_WIDTH - 1));

    localparam logic [1:0] IDLE_SLOT = 2'd0;
    localparam logic [1:0] LEFT      = 2'd1;
    localparam logic [1:0] RIGHT     = 2'd2;

    // ---------------------------------------------------------------- SPI
    logic [SPI_WIDTH-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]      bitcnt_q, bitcnt_d;
    logic [SPI_WIDTH-1:0] word_in;
    logic                 push;
    logic                 ferr_d;

    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        push     = 1'b0;
        ferr_d   = 1'b0;
        word_in  = {shreg_q[SPI_WIDTH-2:0], bus.spi_mosi};
        if (!bus.spi_chip_select) begin
            shreg_d = word_in;
            if (bitcnt_q == BC_LAST) begin
                // last bit: push now so the next word can start immediately
                push     = 1'b1;
                bitcnt_d = '0;
            end else begin
                bitcnt_d = bitcnt_q + BC_W'(1);
            end
        end else if (bitcnt_q != '0) begin
            shreg_d  = '0;
            bitcnt_d = '0;
            ferr_d   = 1'b1;
        end
    end

    // --------------------------------------------------------------- FIFO
    logic [SPI_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wptr_q, rptr_q;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 push_ok;
    logic                 pop;
    logic                 ovr_d;

    assign push_ok = push && (level_q != LVL_FULL);
    assign ovr_d   = push && (level_q == LVL_FULL);

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // storage needs no reset: the pointers define what is valid
    always_ff @(posedge serial_clk) begin
        if (push_ok) mem_q[wptr_q] <= word_in ^ MSB_FLIP;
    end

    // --------------------------------------------------------- serializer
    logic [PH_W-1:0]      ph_q, ph_d;
    logic [1:0]           state_q, state_d;
    logic [I2S_WIDTH-1:0] sr_q, sr_d;
    logic [I2S_WIDTH-1:0] hold_q, hold_d;
    logic [I2S_WIDTH-1:0] head_just;
    logic                 ws_q, ws_d;
    logic                 sd_q;
    logic                 ovr_q, und_q, und_d, ferr_q;
    logic                 left_start, right_start;

    // ph_q is the slot-cycle index the coming edge produces; 0 is left start
    assign left_start  = (ph_q == '0);
    assign right_start = (ph_q == PH_RIGHT);
    assign head_just   = I2S_WIDTH'(mem_q[rptr_q]) << (I2S_WIDTH - SPI_WIDTH);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        und_d   = 1'b0;
        ws_d    = (ph_q >= PH_RIGHT);
        ph_d    = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
        // shift out MSB first; at slot start the remaining top bit is the
        // previous word's LSB, which gives the one-bit I2S delay for free
        sr_d    = sr_q << 1;
        if (left_start) begin
            if (level_q >= LVL_NEED) begin
                pop     = 1'b1;
                sr_d    = head_just;
                hold_d  = head_just;
                state_d = LEFT;
            end else begin
                // stereo waits for a full pair so L/R never slip
                sr_d    = '0;
                und_d   = 1'b1;
                state_d = IDLE_SLOT;
            end
        end else if (right_start) begin
            if (state_q == LEFT) begin
                state_d = RIGHT;
                if (STEREO) begin
                    pop  = 1'b1;
                    sr_d = head_just;
                end else begin
                    sr_d = hold_q;
                end
            end else begin
                sr_d = '0;
            end
        end
    end

    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            ph_q     <= '0;
            state_q  <= IDLE_SLOT;
            sr_q     <= '0;
            hold_q   <= '0;
            ws_q     <= 1'b0;
            sd_q     <= 1'b0;
            ovr_q    <= 1'b0;
            und_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            if (push_ok) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)     rptr_q <= rptr_q + PTR_W'(1);
            level_q  <= level_d;
            ph_q     <= ph_d;
            state_q  <= state_d;
            sr_q     <= sr_d;
            hold_q   <= hold_d;
            ws_q     <= ws_d;
            sd_q     <= sr_q[I2S_WIDTH-1];
            ovr_q    <= ovr_d;
            und_q    <= und_d;
            ferr_q   <= ferr_d;
        end
    end

    assign bus.i2s_ws            = ws_q;
    assign bus.i2s_sound_bit_out = sd_q;
    assign bus.fifo_level        = level_q;
    assign bus.overrun_pulse     = ovr_q;
    assign bus.underrun_pulse    = und_q;
    assign bus.frame_error_pulse = ferr_q;
endmodule

// File: tb/tb_audio_spi_i2s_bridge.sv
// Bench for audio_spi_i2s_bridge: two instances share the SPI stimulus,
// one stereo/two's complement, one mono/offset binary. A queue-based model
// predicts FIFO occupancy, pulses and each played L/R frame; a monitor
// deserializes the I2S stream and checks it against the predicted frames.
module tb_audio_spi_i2s_bridge;
    localparam int SPI_W = 12;
    localparam int I2S_W = 16;
    localparam int DEPTH = 4;
    localparam bit [1:0] ST = 2'b01;   // instance 0 stereo, 1 mono
    localparam bit [1:0] SG = 2'b01;   // instance 0 signed, 1 offset binary

    logic clk = 1'b0;
    logic rst_n;
    logic cs, mosi;
    always #5 clk = ~clk;

    audio_spi_i2s_bridge_if #(.FIFO_DEPTH(DEPTH)) if0 ();
    audio_spi_i2s_bridge_if #(.FIFO_DEPTH(DEPTH)) if1 ();
    assign if0.spi_chip_select = cs;
    assign if0.spi_mosi        = mosi;
    assign if1.spi_chip_select = cs;
    assign if1.spi_mosi        = mosi;

    audio_spi_i2s_bridge #(.SPI_WIDTH(SPI_W), .I2S_WIDTH(I2S_W), .FIFO_DEPTH(DEPTH),
                           .STEREO(1'b1), .SIGNED_IN(1'b1))
        u_dut0 (.serial_clk(clk), .reset(rst_n), .bus(if0));
    audio_spi_i2s_bridge #(.SPI_WIDTH(SPI_W), .I2S_WIDTH(I2S_W), .FIFO_DEPTH(DEPTH),
                           .STEREO(1'b0), .SIGNED_IN(1'b0))
        u_dut1 (.serial_clk(clk), .reset(rst_n), .bus(if1));

    logic       ws_w [2], sd_w [2], ov_w [2], un_w [2], fe_w [2];
    logic [2:0] lv_w [2];
    assign ws_w[0] = if0.i2s_ws;            assign ws_w[1] = if1.i2s_ws;
    assign sd_w[0] = if0.i2s_sound_bit_out; assign sd_w[1] = if1.i2s_sound_bit_out;
    assign ov_w[0] = if0.overrun_pulse;     assign ov_w[1] = if1.overrun_pulse;
    assign un_w[0] = if0.underrun_pulse;    assign un_w[1] = if1.underrun_pulse;
    assign fe_w[0] = if0.frame_error_pulse; assign fe_w[1] = if1.frame_error_pulse;
    assign lv_w[0] = if0.fifo_level;        assign lv_w[1] = if1.fifo_level;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d] got %h expected %h at %0t", nm, i, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] just(logic [11:0] x);
        return 16'(x) * 16'(1 << (I2S_W - SPI_W));
    endfunction

    // ------------------------------------------------------------ model
    logic [11:0] fifo_m [2][$];
    logic [31:0] exp_f  [2][$];
    bit          rpend  [2];
    bit          m_ov [2], m_un [2], m_fe [2];
    int          m_lv [2];
    int          acc, nb, mt;

    always @(posedge clk) begin : model
        int sz0, ph;
        logic [11:0] w, l, r;
        bit done, fe;
        if (!rst_n) begin
            acc = 0; nb = 0; mt = 0;
            for (int i = 0; i < 2; i++) begin
                fifo_m[i].delete(); exp_f[i].delete();
                rpend[i] = 0; m_ov[i] = 0; m_un[i] = 0; m_fe[i] = 0; m_lv[i] = 0;
            end
        end else begin
            done = 0; fe = 0;
            if (!cs) begin
                acc = (acc * 2 + int'(mosi)) % (1 << SPI_W);
                nb++;
                if (nb == SPI_W) begin done = 1; nb = 0; end
            end else if (nb != 0) begin
                fe = 1; nb = 0; acc = 0;
            end
            ph = mt % (2 * I2S_W);
            for (int i = 0; i < 2; i++) begin
                sz0 = fifo_m[i].size();
                m_ov[i] = 0; m_un[i] = 0; m_fe[i] = fe;
                if (ph == 0) begin
                    if (sz0 >= (ST[i] ? 2 : 1)) begin
                        l = fifo_m[i].pop_front();
                        r = ST[i] ? fifo_m[i][0] : l;
                        rpend[i] = ST[i];
                        exp_f[i].push_back({just(l), just(r)});
                    end else begin
                        exp_f[i].push_back(32'd0);
                        m_un[i] = 1;
                    end
                end
                if (ph == I2S_W && rpend[i]) begin
                    void'(fifo_m[i].pop_front());
                    rpend[i] = 0;
                end
                if (done) begin
                    w = SG[i] ? 12'(acc) : (12'(acc) ^ 12'h800);
                    if (sz0 == DEPTH) m_ov[i] = 1;
                    else fifo_m[i].push_back(w);
                end
                m_lv[i] = fifo_m[i].size();
            end
            if (done) acc = 0;
            mt++;
        end
    end

    // ---------------------------------------------------------- monitor
    logic [15:0] accl [2], accr [2];
    int          tm = 0;

    always @(negedge clk) begin : monitor
        int ph;
        logic [31:0] e;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                chk("reset_outputs", i,
                    32'({ws_w[i], sd_w[i], ov_w[i], un_w[i], fe_w[i], lv_w[i]}), 32'd0);
                accl[i] = 0; accr[i] = 0;
            end else begin
                ph = tm % (2 * I2S_W);
                chk("ws", i, 32'(ws_w[i]), 32'(ph >= I2S_W));
                chk("fifo_level", i, 32'(lv_w[i]), 32'(m_lv[i]));
                chk("pulses_ov_un_fe", i, 32'({ov_w[i], un_w[i], fe_w[i]}),
                    32'({m_ov[i], m_un[i], m_fe[i]}));
                if (ph >= 1 && ph <= I2S_W) accl[i] = {accl[i][14:0], sd_w[i]};
                else                        accr[i] = {accr[i][14:0], sd_w[i]};
                if (ph == 0 && tm > 0) begin
                    if (exp_f[i].size() == 0) begin
                        chk("frame_expected", i, 32'd0, 32'd1);
                    end else begin
                        e = exp_f[i].pop_front();
                        chk("frame_LR", i, {accl[i], accr[i]}, e);
                    end
                end
            end
        end
        if (!rst_n) tm = 0;
        else tm++;
    end

    // --------------------------------------------------------- stimulus
    task automatic send(logic [11:0] w, int n);
        for (int b = 0; b < n; b++) begin
            @(posedge clk); #2;
            cs = 1'b0; mosi = w[11-b];
        end
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #2;
            cs = 1'b1; mosi = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0; cs = 1'b1;
        repeat (3) @(posedge clk);
        // release just after a falling edge so the next rising edge is cycle 0
        @(negedge clk); #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; cs = 1'b1; mosi = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        idle(70);
        send(12'hFFF, 12); send(12'h801, 12); idle(70);
        send(12'h5A5, 7); idle(3); send(12'hABC, 12); idle(70);
        send(12'h800, 12); send(12'h000, 12); idle(70);
        send(12'h123, 12); idle(70);
        for (int k = 0; k < 10; k++) send(12'($urandom), 12);
        idle(150);
        for (int k = 0; k < 60; k++) begin
            n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 11)) : SPI_W;
            send(12'($urandom), n);
            if (n != SPI_W || $urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 40)));
        end
        idle(100);
        send(12'h3C3, 12); send(12'hC3C, 12); send(12'h7FF, 5);
        do_reset();
        idle(70);
        for (int k = 0; k < 40; k++) begin
            send(12'($urandom), SPI_W);
            if ($urandom_range(0, 1) != 0) idle(int'($urandom_range(1, 30)));
        end
        idle(100);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/audio_spi_i2s_bridge.md
# audio_spi_i2s_bridge

Parametrised SPI-in / I2S-out audio bridge; successor to the fixed 12-bit mono transceiver. Captures SPI_WIDTH-bit samples from an SPI master, optionally converts offset-binary to two's complement, and buffers them in a FIFO_DEPTH-entry FIFO. A free-running I2S serializer left-justifies each sample into I2S_WIDTH-bit mono or stereo slots. Sits between the ADC/MCU SPI link and the DAC I2S input, all on `serial_clk`.

## Interface
- SPI_WIDTH, 12, bits per SPI sample word (≥2).
- I2S_WIDTH, 16, bits per I2S channel slot (≥ SPI_WIDTH).
- FIFO_DEPTH, 4, sample FIFO entries (power of 2, ≥2).
- STEREO, 1, 1 means consecutive SPI words are L,R pairs; 0 means each word is played on both channels.
- SIGNED_IN, 1, 1 means SPI words are two's complement; 0 means offset binary, converted by inverting the MSB.
- serial_clk  in  1  single clock, shared by SPI capture and I2S bit clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- spi_chip_select  in  1  active-low SPI frame enable.
- spi_mosi  in  1  SPI data, MSB first.
- i2s_ws  out  1  word select: 0 = left slot, 1 = right slot.
- i2s_sound_bit_out  out  1  I2S serial data.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- overrun_pulse  out  1  one-cycle pulse: completed word dropped because the FIFO was full.
- underrun_pulse  out  1  one-cycle pulse: left slot started without enough data.
- frame_error_pulse  out  1  one-cycle pulse: chip select rose mid-word.

## Operation
- Reset (reset=0): shift register, bit counter, FIFO pointers, slot counter, and all outputs cleared to 0; i2s_ws=0.
- SPI capture: while spi_chip_select=0, shift spi_mosi in on each rising edge. The bit counter runs 0..SPI_WIDTH-1. On the SPI_WIDTH-th bit, the completed word (including that bit) is pushed and the counter returns to 0, so back-to-back words are accepted without deasserting chip select.
- spi_chip_select=1 with bit counter ≠0: discard the partial word, clear the counter, pulse frame_error_pulse. At counter=0: no effect.
- Conversion at push: if SIGNED_IN=0, invert the MSB. Stored width is SPI_WIDTH. At pop, left-justify to I2S_WIDTH and zero-fill the LSBs.
- FIFO: push when full → word dropped, overrun_pulse. Simultaneous push and pop both take effect; level unchanged.
- Serializer FSM states:
  - IDLE_SLOT: a zero word is loaded for the slot.
  - LEFT: ws=0.
  - RIGHT: ws=1.
- Slot sequencing: the slot counter runs 0..I2S_WIDTH-1 free, starting after reset. ws toggles when the counter wraps.
- Left-slot start, STEREO=1: if fifo_level ≥2, pop L now and pop R at right-slot start. Otherwise load zero for both slots, pop nothing, and pulse underrun_pulse. This preserves L/R alignment.
- Left-slot start, STEREO=0: if fifo_level ≥1, pop one word and use it for both slots. Otherwise load zeros and pulse underrun_pulse.
- Data format: standard I2S one-bit delay. Word bit I2S_WIDTH-1 (MSB) is driven in slot cycle 1. Bit I2S_WIDTH-1-k is driven in slot cycle k+1. The LSB is driven in cycle 0 of the following slot.

## Timing
- All outputs are registered. fifo_level updates the cycle after a push or pop.
- Capture latency: push occurs on the edge sampling the last bit. The earliest output is the next left-slot start, whose MSB appears in slot cycle 1.
- Pulses are exactly one cycle and may coincide with each other.
- i2s_ws period: 2·I2S_WIDTH cycles. First left slot begins on the first edge after reset release.
- Reset mid-operation: immediate return to reset values. The partial word and FIFO contents are lost, and no pulses are generated.

## Test plan
Defaults unless stated: SPI_WIDTH=12, I2S_WIDTH=16, FIFO_DEPTH=4, STEREO=1, SIGNED_IN=1.
- Reset release, no SPI traffic → i2s_ws toggles every 16 cycles, data constant 0, underrun_pulse once every 32 cycles, fifo_level=0.
- SPI words 12'hFFF then 12'h801 (24 cycles, chip select held low) → fifo_level reaches 2. Next left slot shifts 16'hFFF0 MSB-first from slot cycle 1; right slot shifts 16'h8010; fifo_level returns to 0.
- Chip select raised after 7 bits → frame_error_pulse for one cycle; fifo_level unchanged. A following full 12'hABC is captured correctly.
- Chip select held low for 10 consecutive words from an empty FIFO → fifo_level never exceeds 4; overrun_pulse asserted ≥1 time; played L/R pairs match the earliest accepted words in order.
- SIGNED_IN=0: words 12'h800, 12'h000 → slots carry 16'h0000 and 16'h8000. STEREO=0: single word 12'h123 → both L and R slots carry 16'h1230.
- reset asserted mid-word with 2 words buffered → all outputs 0 on that cycle. After release, fifo_level=0 and the next left slot underruns.
